clause_dispatch_buffer: RTL and testbench
=========================================

CLAUSE_DISPATCH_BUFFER -- requirements
Module: clause_dispatch_buffer

Interface
REQ-001 Parameter NUM_ENGINE, default 4: number of solver engines; sets the maximum clauses presented per cycle.
REQ-002 Parameter DEPTH, default 8: buffer entries; power of two, at least NUM_ENGINE.
REQ-003 Parameter CLA_W, default 33: clause width, CLA_LENGTH(3) x VARIABLE_LENGTH(11).
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: begin a clause-load run; sampled only in IDLE.
REQ-007 Port abort, input, 1: flush the buffer and return to IDLE.
REQ-008 Port total_clauses, input, 16: clauses in the run; latched on accepted start.
REQ-009 Port mem_valid, input, 1: mem_clause is valid.
REQ-010 Port mem_clause, input, CLA_W: incoming clause from clause memory.
REQ-011 Port mem_ready, output, 1: buffer accepts mem_clause this cycle.
REQ-012 Port clause_distributed, output, NUM_ENGINE x CLA_W: oldest buffered clauses, slot 0 oldest.
REQ-013 Port clause_cnt, output, clog2(NUM_ENGINE)+1: number of valid slots in clause_distributed.
REQ-014 Port clause_accept, input, clog2(NUM_ENGINE)+1: clauses the arbiter consumed this cycle.
REQ-015 Port busy, output, 1: state is not IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when all total_clauses have been loaded and consumed.
REQ-017 Port accept_err, output, 1: sticky; set when clause_accept exceeds clause_cnt.

Function
REQ-018 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start with total_clauses != 0.
- IDLE->DONE on start with total_clauses == 0.
- RUN->DONE when loaded == total and count == 0.
- DONE->IDLE unconditionally on the next cycle.
REQ-019 done SHALL be 1 only in the DONE state.
REQ-020 The buffer SHALL be a circular queue with head pointer, tail pointer and a count register of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-021 mem_ready SHALL equal (state == RUN) && (count < DEPTH) && (loaded < total), computed from registered count only, with no same-cycle pop bypass.
REQ-022 A push SHALL occur on mem_valid && mem_ready: write to tail, then tail+1 and loaded+1.
REQ-023 clause_cnt SHALL equal min(count, NUM_ENGINE) in RUN and 0 otherwise.
REQ-024 Slot i SHALL equal entry[(head+i) mod DEPTH] for i < clause_cnt, and 0 otherwise; this path is combinational from registered state.
REQ-025 A pop SHALL occur in RUN: head += min(clause_accept, clause_cnt), and count decreases by the same amount.
REQ-026 If clause_accept > clause_cnt, the pop SHALL be clamped to clause_cnt and accept_err set.
REQ-027 A simultaneous push and pop SHALL give count_next = count + push - pop; a full buffer with a same-cycle pop SHALL still not push (per REQ-021).
REQ-028 clause_accept SHALL be ignored outside RUN.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 abort SHALL take priority over every other event: next state IDLE; head, tail, count and loaded cleared; no push or pop that cycle; done not pulsed.
REQ-031 A clause's latency from push to visibility on clause_distributed SHALL be one cycle.

Reset
REQ-032 On reset the block SHALL enter IDLE and clear head, tail, count, loaded, total and accept_err.
REQ-033 After reset, mem_ready, clause_cnt, clause_distributed, busy, done and accept_err SHALL all be 0.
REQ-034 Reset mid-run SHALL discard buffered clauses, and reset SHALL take priority over abort.
REQ-035 Buffer data storage needs no reset.

Structure
REQ-036 A shared package SHALL hold LIT_IDX_MAX=1024, CLA_LENGTH=3, NUM_ENGINE=4, VARIABLE_LENGTH, the clause typedef (CLA_W bits) and the FSM state enum.
REQ-037 The circular queue SHALL be one sub-module, clause_mpop_fifo: single push, multi-pop of up to NUM_ENGINE entries, peek window of NUM_ENGINE entries.
REQ-038 The FSM and loaded/total counters SHALL live in the top module.

Verification
REQ-039 Basic run: total=5, mem_valid held high, clause_accept=clause_cnt every cycle -> clause_cnt sequence 1,1,1,1,1; done pulses exactly once; mem_ready=0 after the 5th push.
REQ-040 Fill and multi-pop: total=10, clause_accept=0 until full -> mem_ready=0 at count 8 and clause_cnt=4; then clause_accept=4 -> count 4 next cycle; push resumes; FIFO order preserved across pointer wrap.
REQ-041 Over-accept: count=2, clause_accept=3 -> head advances 2, count 0, accept_err=1 and stays 1 until reset.
REQ-042 Zero-length run: start with total=0 -> done at cycle+1, IDLE at cycle+2, mem_ready never 1.
REQ-043 Abort mid-run: total=20, abort at count=6 -> next cycle IDLE, clause_cnt=0, busy=0, no done; a new start with total=3 delivers exactly the 3 new clauses.
REQ-044 Simultaneous push and pop: count=4, push 1, clause_accept=2 -> count=3; reset asserted mid-run -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/clause_dispatch_buffer_pkg.sv
// Shared constants and types for the clause dispatch buffer: clause geometry
// and the run-control state encoding.
package clause_dispatch_buffer_pkg;

  localparam int LIT_IDX_MAX     = 1024;
  localparam int CLA_LENGTH      = 3;
  localparam int NUM_ENGINE      = 4;
  // Literal index plus one sign bit.
  localparam int VARIABLE_LENGTH = $clog2(LIT_IDX_MAX) + 1;
  localparam int CLA_W           = CLA_LENGTH * VARIABLE_LENGTH;

  typedef logic [CLA_W-1:0] clause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/clause_mpop_fifo.sv
// Circular clause queue: one push per cycle, pop of up to NUM_ENGINE entries,
// and a NUM_ENGINE-wide peek window starting at the head.
module clause_mpop_fifo
  import clause_dispatch_buffer_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int NUM_ENGINE = 4,
  parameter  int W          = 33,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CW         = PTR_W + 1,
  localparam int NW         = $clog2(NUM_ENGINE) + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  logic [W-1:0]                   i_data,
  input  logic [NW-1:0]                  i_pop_n,
  output logic [CW-1:0]                  o_count,
  output logic [NW-1:0]                  o_avail,
  output logic [NUM_ENGINE-1:0][W-1:0]   o_peek
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CW-1:0]    r_count;

  // Pointer arithmetic is PTR_W wide so wrap modulo DEPTH comes for free.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      r_head  <= r_head + PTR_W'(i_pop_n);
      r_count <= r_count + CW'(i_push) - CW'(i_pop_n);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_data;
  end

  always_comb begin
    o_avail = NW'(r_count);
    if (r_count > CW'(NUM_ENGINE)) o_avail = NW'(NUM_ENGINE);
  end

  always_comb begin
    for (int i = 0; i < NUM_ENGINE; i++) begin
      o_peek[i] = r_mem[r_head + PTR_W'(i)];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/clause_dispatch_buffer.sv
// Clause dispatch buffer: loads a run of clauses from clause memory and
// presents the oldest NUM_ENGINE of them to the engine arbiter each cycle.
// Handshakes: a clause moves in on mem_valid && mem_ready; the arbiter takes
// clause_accept clauses from slot 0 upward in the same cycle they are shown.
module clause_dispatch_buffer
  import clause_dispatch_buffer_pkg::*;
#(
  parameter  int NUM_ENGINE = 4,
  parameter  int DEPTH      = 8,
  parameter  int CLA_W      = 33,
  localparam int CW         = $clog2(DEPTH) + 1,
  localparam int NW         = $clog2(NUM_ENGINE) + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [15:0]                       total_clauses,
  input  logic                              mem_valid,
  input  logic [CLA_W-1:0]                  mem_clause,
  output logic                              mem_ready,
  output logic [NUM_ENGINE-1:0][CLA_W-1:0]  clause_distributed,
  output logic [NW-1:0]                     clause_cnt,
  input  logic [NW-1:0]                     clause_accept,
  output logic                              busy,
  output logic                              done,
  output logic                              accept_err,
  output state_t                            o_state
);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [15:0]                     r_total;
  logic [15:0]                     r_loaded;
  logic                            r_accept_err;
  logic                            w_run;
  logic                            w_start_ok;
  logic                            w_push;
  logic                            w_over;
  logic [NW-1:0]                   w_pop_n;
  logic [CW-1:0]                   w_count;
  logic [NW-1:0]                   w_avail;
  logic [NUM_ENGINE-1:0][CLA_W-1:0] w_peek;

  assign w_run     = (r_state == ST_RUN);
  // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot early.
  assign mem_ready = w_run && (w_count < CW'(DEPTH)) && (r_loaded < r_total);
  assign w_push    = mem_valid && mem_ready && !abort;
  assign w_over    = (clause_accept > clause_cnt);
  assign w_pop_n   = (w_run && !abort) ? (w_over ? clause_cnt : clause_accept) : '0;

  clause_mpop_fifo #(
    .DEPTH      (DEPTH),
    .NUM_ENGINE (NUM_ENGINE),
    .W          (CLA_W)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_flush (abort),
    .i_push  (w_push),
    .i_data  (mem_clause),
    .i_pop_n (w_pop_n),
    .o_count (w_count),
    .o_avail (w_avail),
    .o_peek  (w_peek)
  );

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          w_start_ok   = 1'b1;
          w_state_next = (total_clauses != 16'd0) ? ST_RUN : ST_DONE;
        end
        ST_RUN:  if ((r_loaded == r_total) && (w_count == '0)) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_total      <= '0;
      r_loaded     <= '0;
      r_accept_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (abort)           r_loaded <= '0;
      else if (w_start_ok) begin
        r_total  <= total_clauses;
        r_loaded <= '0;
      end else if (w_push) r_loaded <= r_loaded + 16'd1;
      if (w_run && !abort && w_over) r_accept_err <= 1'b1;
    end
  end

  assign clause_cnt = w_run ? w_avail : '0;

  always_comb begin
    for (int i = 0; i < NUM_ENGINE; i++) begin
      clause_distributed[i] = (NW'(i) < clause_cnt) ? w_peek[i] : '0;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign accept_err = r_accept_err;
  assign o_state    = r_state;

endmodule

// File: tb/tb_clause_dispatch_buffer.sv
// Bench for clause_dispatch_buffer: a cycle model with a clause queue predicts
// every output; directed runs cover fill, wrap, over-accept, abort and reset.
module tb_clause_dispatch_buffer;
  import clause_dispatch_buffer_pkg::*;

  localparam int NE = 4;
  localparam int DP = 8;
  localparam int CLW = 33;
  localparam int NW = $clog2(NE) + 1;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     abort;
  logic [15:0]              total_clauses;
  logic                     mem_valid;
  logic [CLW-1:0]           mem_clause;
  logic                     mem_ready;
  logic [NE-1:0][CLW-1:0]   clause_distributed;
  logic [NW-1:0]            clause_cnt;
  logic [NW-1:0]            clause_accept;
  logic                     busy;
  logic                     done;
  logic                     accept_err;
  state_t                   o_state;

  clause_dispatch_buffer #(.NUM_ENGINE(NE), .DEPTH(DP), .CLA_W(CLW)) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .total_clauses      (total_clauses),
    .mem_valid          (mem_valid),
    .mem_clause         (mem_clause),
    .mem_ready          (mem_ready),
    .clause_distributed (clause_distributed),
    .clause_cnt         (clause_cnt),
    .clause_accept      (clause_accept),
    .busy               (busy),
    .done               (done),
    .accept_err         (accept_err),
    .o_state            (o_state)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [CLW-1:0] exp_q[$];
  state_t         m_state;
  int             m_total;
  int             m_loaded;
  logic           m_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen;
  int cnt1_seen;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int m_cnt_out();
    if (m_state != ST_RUN) return 0;
    return (exp_q.size() > NE) ? NE : exp_q.size();
  endfunction

  function automatic logic [CLW-1:0] rnd_cla();
    return {1'($urandom), 32'($urandom)};
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_state  = ST_IDLE;
    m_total  = 0;
    m_loaded = 0;
    m_err    = 1'b0;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic st, input logic ab, input logic [15:0] tot,
                      input logic vld, input logic [CLW-1:0] cla, input logic [NW-1:0] acc);
    int     cnt;
    int     pop;
    logic   rdy;
    state_t nxt;
    start = st; abort = ab; total_clauses = tot;
    mem_valid = vld; mem_clause = cla; clause_accept = acc;
    #1;
    cnt = m_cnt_out();
    rdy = (m_state == ST_RUN) && (exp_q.size() < DP) && (m_loaded < m_total);
    check_eq("mem_ready", mem_ready, rdy);
    check_eq("clause_cnt", clause_cnt, cnt);
    check_eq("busy", busy, m_state != ST_IDLE);
    check_eq("done", done, m_state == ST_DONE);
    check_eq("accept_err", accept_err, m_err);
    check_eq("state", o_state, m_state);
    for (int i = 0; i < NE; i++)
      check_eq($sformatf("slot%0d", i), clause_distributed[i], (i < cnt) ? exp_q[i] : '0);
    if (done) done_seen++;
    if (clause_cnt == 1) cnt1_seen++;

    if (ab) begin
      m_state = ST_IDLE;
      exp_q.delete();
      m_loaded = 0;
    end else begin
      case (m_state)
        ST_IDLE: if (st) begin
          m_total  = tot;
          m_loaded = 0;
          m_state  = (tot != 0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          nxt = (m_loaded == m_total && exp_q.size() == 0) ? ST_DONE : ST_RUN;
          pop = (acc > cnt) ? cnt : int'(acc);
          if (acc > cnt) m_err = 1'b1;
          repeat (pop) void'(exp_q.pop_front());
          if (vld && rdy) begin
            exp_q.push_back(cla);
            m_loaded++;
          end
          m_state = nxt;
        end
        default: m_state = ST_IDLE;
      endcase
    end
    @(posedge clock);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_ready"}, mem_ready, 0);
    check_eq({tag, "_clause_cnt"}, clause_cnt, 0);
    check_eq({tag, "_slots"}, clause_distributed, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_accept_err"}, accept_err, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; abort = 0; mem_valid = 0; clause_accept = 0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  // Drain with the arbiter taking everything offered, until the model is idle.
  task automatic drain_full_accept();
    for (int c = 0; c < 100; c++) begin
      if (m_state == ST_IDLE) break;
      step(0, 0, 0, 1, rnd_cla(), NW'(m_cnt_out()));
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; total_clauses = 0;
    mem_valid = 0; mem_clause = 0; clause_accept = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    check_all_zero("reset");

    // Basic run of 5 clauses
    done_seen = 0; cnt1_seen = 0;
    step(1, 0, 16'd5, 0, '0, 0);
    drain_full_accept();
    check_eq("basic_done_pulses", done_seen, 1);
    check_eq("basic_cnt1_cycles", cnt1_seen, 5);

    // Fill to full, multi-pop, then drain across the pointer wrap
    step(1, 0, 16'd10, 0, '0, 0);
    for (int c = 0; c < 20 && exp_q.size() < DP; c++) step(0, 0, 0, 1, rnd_cla(), 0);
    #1;
    check_eq("full_mem_ready", mem_ready, 0);
    check_eq("full_clause_cnt", clause_cnt, 4);
    step(0, 0, 0, 1, rnd_cla(), 4);
    step(0, 0, 0, 1, rnd_cla(), 0);
    drain_full_accept();

    // Over-accept: two buffered, three taken
    step(1, 0, 16'd2, 0, '0, 0);
    for (int c = 0; c < 10 && m_loaded < 2; c++) step(0, 0, 0, 1, rnd_cla(), 0);
    step(0, 0, 0, 0, '0, 3);
    #1;
    check_eq("over_accept_err", accept_err, 1);
    check_eq("over_accept_cnt", clause_cnt, 0);
    drain_full_accept();
    check_eq("over_accept_sticky", accept_err, 1);

    // Zero-length run
    step(1, 0, 16'd0, 1, rnd_cla(), 0);
    #1;
    check_eq("zero_done", done, 1);
    step(0, 0, 0, 1, rnd_cla(), 0);
    #1;
    check_eq("zero_idle_busy", busy, 0);
    check_eq("zero_idle_done", done, 0);

    // Abort mid-run at count 6, then a fresh short run
    done_seen = 0;
    step(1, 0, 16'd20, 0, '0, 0);
    for (int c = 0; c < 20 && exp_q.size() < 6; c++) step(0, 0, 0, 1, rnd_cla(), 0);
    step(0, 1, 0, 1, rnd_cla(), 2);
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_clause_cnt", clause_cnt, 0);
    check_eq("abort_done_pulses", done_seen, 0);
    step(1, 0, 16'd3, 0, '0, 0);
    drain_full_accept();

    // Simultaneous push and pop, then reset mid-run
    do_reset();
    check_all_zero("reset2");
    step(1, 0, 16'd10, 0, '0, 0);
    for (int c = 0; c < 20 && exp_q.size() < 4; c++) step(0, 0, 0, 1, rnd_cla(), 0);
    step(0, 0, 0, 1, rnd_cla(), 2);
    #1;
    check_eq("simul_clause_cnt", clause_cnt, 3);
    do_reset();
    check_all_zero("midrun_reset");

    // Random traffic: irregular valid and accept, stray start requests
    step(1, 0, 16'd12, 0, '0, 0);
    for (int c = 0; c < 300; c++) begin
      if (m_state == ST_IDLE) break;
      step(1'($urandom_range(0, 1)), 0, 16'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), rnd_cla(), NW'($urandom_range(0, NE)));
    end
    step(0, 0, 0, 0, '0, NW'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
